regfile_write_arbiter: RTL and testbench

//  Sequences the single write port of the 32x32 register bank. Shares it between
//  NUM_REQ writeback requesters (e.g. ALU, load, jal link) using valid/ready round-robin.

---
 rtl/regfile_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the single write port of the register bank. It shares the port between
// NUM_REQ writeback requesters using valid/ready handshakes. It also runs a
// zero-fill sweep over every register after reset and whenever clear_start
// is pulsed.
// Build option: define REGARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority, where the lowest index wins and no rotation pointer exists.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

`ifdef REGARB_FIXED_PRIO_EN
    // Pick the lowest-index valid requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
                grant_any = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    int               scan_idx;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_any && req_valid[IDX_W'(scan_idx)]) begin
                grant[IDX_W'(scan_idx)] = 1'b1;
                grant_idx = IDX_W'(scan_idx);
                grant_any = 1'b1;
            end
        end
    end

    // After each accept, move the rotation pointer to the slot just past the winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // A grant counts only in RUN, and only when no clear is being requested.
    // A clear request takes priority over a pending write.
    assign accept   = (state == RUN) && !clear_start && grant_any;
    assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Leave the sweep when the last address is written; re-enter it on clear_start
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (!clear_start && clr_cnt == LAST_ADDR) next_state = RUN;
            RUN:     if (clear_start) next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // Handshake and status outputs follow the current state
    always_comb begin
        req_ready  = accept ? grant : '0;
        clear_busy = (state == CLEAR);
    end

    // Register the write-port command: either a sweep write or the accepted
    // requester. Accepted writes to $0 keep wr_en low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_data <= '0;
                    if (clear_start) begin
                        wr_addr <= '0;
                        clr_cnt <= ADDR_W'(1);
                    end else begin
                        wr_addr <= clr_cnt;
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clear_start) begin
                        wr_en   <= 1'b0;
                        clr_cnt <= '0;
                    end else if (accept) begin
                        wr_en   <= (sel_addr != '0);
                        wr_addr <= sel_addr;
                        wr_data <= sel_data;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Bench for regfile_write_arbiter at its default size (3 requesters, 32x32 bank).
// The bench has three parts:
//  - a table of hand-computed vectors,
//  - hand-written reset, sweep and clear sequences,
//  - a randomized phase scored against a behavioural model.
// Define REGARB_FIXED_PRIO_EN for the bench and the design together.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            clear_start;
    logic            clear_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    int numVectors = 0;
    int numBad     = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic            clr;
        logic [N-1:0]    expReady;
        logic            expEn;
        logic            chkAddrData;
        logic [AW-1:0]   expAddr;
        logic [DW-1:0]   expData;
    } vec_t;

    vec_t vecs[11];

    // Behavioural reference state for the random phase
    bit            mBusy;
    int            mCnt;
    int            mPtr;
    bit            mEn;
    int            mAddr;
    logic [DW-1:0] mData;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numVectors++;
        if (act !== exp) begin
            numBad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                                 input logic [N*DW-1:0] d, input logic cs);
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        clear_start = cs;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return the index the arbitration rules pick, or -1 if none is chosen
    function automatic int modelGrant(input logic [N-1:0] v, input logic cs);
        if (mBusy || cs) return -1;
`ifdef REGARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(mPtr + k) % N]) return (mPtr + k) % N;
`endif
        return -1;
    endfunction

    initial begin
        logic [N-1:0]  v;
        logic [AW-1:0] pAddr[N];
        logic [DW-1:0] pData[N];
        bit            pending[N];
        logic          cs;
        int            g;

        // Hand-computed table. It starts right after the first sweep, when the pointer is 0.
`ifdef REGARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            vecs[i] = '{3'b110, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 3'b010, 1'b1, 1'b1, 5'd2, 32'hB};
`else
        vecs[0] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 3'b001, 1'b1, 1'b1, 5'd1, 32'hA};
        vecs[1] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 3'b010, 1'b1, 1'b1, 5'd2, 32'hB};
        vecs[2] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 3'b100, 1'b1, 1'b1, 5'd3, 32'hC};
        vecs[3] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 3'b001, 1'b1, 1'b1, 5'd1, 32'hA};
`endif
        vecs[4] = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hFFFF_FFFF}, 1'b0, 3'b001, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[5] = '{3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0}, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[6] = '{3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h55, 32'h0}, 1'b0, 3'b010, 1'b1, 1'b1, 5'd5, 32'h55};
        vecs[7] = '{3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0}, 1'b0, 3'b000, 1'b0, 1'b1, 5'd5, 32'h55};
        vecs[8] = '{3'b011, {5'd0, 5'd8, 5'd7}, {32'h0, 32'h88, 32'h77}, 1'b0, 3'b001, 1'b1, 1'b1, 5'd7, 32'h77};
        vecs[9] = '{3'b010, {5'd0, 5'd8, 5'd7}, {32'h0, 32'h88, 32'h77}, 1'b0, 3'b010, 1'b1, 1'b1, 5'd8, 32'h88};
`ifdef REGARB_FIXED_PRIO_EN
        vecs[10] = '{3'b101, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 1'b0, 3'b001, 1'b1, 1'b1, 5'd6, 32'h66};
`else
        vecs[10] = '{3'b101, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 1'b0, 3'b100, 1'b1, 1'b1, 5'd4, 32'h44};
`endif

        // Reset state
        reset = 1'b1;
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset_wr_data", wr_data, 32'd0);
        checkOutput("reset_busy", 32'(clear_busy), 32'd1);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sweep after reset: addresses 0..31 with zero data, then idle
        for (int k = 0; k < 32; k++) begin
            step();
            checkOutput("sweep_en", 32'(wr_en), 32'd1);
            checkOutput("sweep_addr", 32'(wr_addr), 32'(k));
            checkOutput("sweep_data", wr_data, 32'd0);
            checkOutput("sweep_busy", 32'(clear_busy), (k < 31) ? 32'd1 : 32'd0);
        end

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].clr);
            checkOutput($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
            step();
            checkOutput($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].expEn));
            if (vecs[i].chkAddrData) begin
                checkOutput($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].expAddr));
                checkOutput($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].expData);
            end
        end

        // A clear request wins over a same-cycle request; that request is granted after the sweep
        applyStimulus(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h99, 32'h0}, 1'b1);
        checkOutput("clr_ready", 32'(req_ready), 32'd0);
        step();
        checkOutput("clr_wr_en", 32'(wr_en), 32'd0);
        checkOutput("clr_busy", 32'(clear_busy), 32'd1);
        clear_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checkOutput("clr_sweep_ready", 32'(req_ready), 32'd0);
            step();
            checkOutput("clr_sweep_addr", 32'(wr_addr), 32'(k));
            checkOutput("clr_sweep_en", 32'(wr_en), 32'd1);
        end
        #1;
        checkOutput("clr_after_busy", 32'(clear_busy), 32'd0);
        checkOutput("clr_after_ready", 32'(req_ready), 32'd2);
        step();
        checkOutput("clr_after_en", 32'(wr_en), 32'd1);
        checkOutput("clr_after_addr", 32'(wr_addr), 32'd9);
        checkOutput("clr_after_data", wr_data, 32'h99);

        // Reset in the middle of a sweep
        applyStimulus(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h99, 32'h0}, 1'b0);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) step();
        checkOutput("mid_pre_addr", 32'(wr_addr), 32'd16);
        reset = 1'b1;
        #1;
        checkOutput("mid_wr_en", 32'(wr_en), 32'd0);
        checkOutput("mid_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("mid_busy", 32'(clear_busy), 32'd1);
        checkOutput("mid_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        checkOutput("mid_restart_addr0", 32'(wr_addr), 32'd0);
        checkOutput("mid_restart_en", 32'(wr_en), 32'd1);
        step();
        checkOutput("mid_restart_addr1", 32'(wr_addr), 32'd1);

        // Randomized phase against the behavioural model, starting from a fresh reset
        reset = 1'b1;
        applyStimulus('0, '0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        mBusy = 1; mCnt = 0; mPtr = 0; mEn = 0; mAddr = 0; mData = '0;
        for (int i = 0; i < N; i++) begin
            pending[i] = 0;
            pAddr[i]   = '0;
            pData[i]   = '0;
        end
        #2;
        for (int cyc = 0; cyc < 700; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(3) != 0)) begin
                    pending[i] = 1;
                    pAddr[i]   = AW'($urandom_range(31));
                    pData[i]   = $urandom;
                end
                v[i] = pending[i];
            end
            cs = !mBusy && ($urandom_range(63) == 0);
            applyStimulus(v, {pAddr[2], pAddr[1], pAddr[0]}, {pData[2], pData[1], pData[0]}, cs);
            g = modelGrant(v, cs);
            checkOutput("rnd_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            step();
            if (mBusy) begin
                mEn = 1; mAddr = mCnt; mData = '0;
                if (mCnt == 31) mBusy = 0;
                else mCnt++;
            end else if (cs) begin
                mBusy = 1; mCnt = 0; mEn = 0;
            end else if (g >= 0) begin
                mEn   = (pAddr[g] != 0);
                mAddr = int'(pAddr[g]);
                mData = pData[g];
                mPtr  = (g + 1) % N;
                pending[g] = 0;
            end else begin
                mEn = 0;
            end
            checkOutput("rnd_wr_en", 32'(wr_en), 32'(mEn));
            checkOutput("rnd_busy", 32'(clear_busy), 32'(mBusy));
            if (mEn) begin
                checkOutput("rnd_wr_addr", 32'(wr_addr), 32'(mAddr));
                checkOutput("rnd_wr_data", wr_data, mData);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numBad);
        $finish;
    end

endmodule
